// File: rtl/morse_keyer_if.sv
`default_nettype none
// ============================================================================
//  Module      : morse_keyer_if
//  Description : Character handshake between the message buffer (master)
//                and the Morse keyer (slave). A character is transferred on
//                any cycle where char_valid and char_ready are both high.
//  Revision    : 1.0 - initial release
// ============================================================================
interface morse_keyer_if;
  logic [5:0] char_in;
  logic       char_valid;
  logic       char_ready;

  modport master (
    output char_in,
    output char_valid,
    input  char_ready
  );

  modport slave (
    input  char_in,
    input  char_valid,
    output char_ready
  );
endinterface
`default_nettype wire

// File: rtl/morse_keyer.sv
`default_nettype none
// ============================================================================
//  Module      : morse_keyer
//  Description : Turns character codes into a Morse on/off key line. One Morse
//                unit is one period of unit_clk, which is synchronised into
//                the CLOCK_50 domain and edge-detected into a single-cycle
//                tick (unit_clk is never used as a clock).
//                Codes: 0-25 A-Z, 26 space, 27-36 digits 0-9 (optional),
//                everything else is reported through bad_char.
//  Options     : `define MORSE_KEYER_DIGITS_EN to add the digit patterns;
//                without it, codes 27-36 are treated as invalid.
//  Revision    : 1.0 - initial release
// ============================================================================
module morse_keyer #(
  parameter int SYNC_STAGES      = 2,
  parameter int DASH_UNITS       = 3,
  parameter int CHAR_GAP_UNITS   = 3,
  parameter int WORD_EXTRA_UNITS = 4
) (
  input  logic         CLOCK_50,
  input  logic         reset_n,
  input  logic         unit_clk,
  morse_keyer_if.slave char_bus,
  output logic         key_out,
  output logic         busy,
  output logic         char_done,
  output logic         bad_char
);

  localparam logic [5:0] CODE_SPACE = 6'd26;
  // Counters run from 0, so the terminal value is one less than the span.
  localparam logic [2:0] DASH_LAST  = 3'(DASH_UNITS - 1);
  localparam logic [2:0] CGAP_LAST  = 3'(CHAR_GAP_UNITS - 1);
  // The first tick after a space only aligns to a unit boundary, so the
  // word gap runs one count further than the number of units it emits.
  localparam logic [2:0] WGAP_LAST  = 3'(WORD_EXTRA_UNITS);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ALIGN    = 3'd1,
    MARK     = 3'd2,
    SYM_GAP  = 3'd3,
    CHAR_GAP = 3'd4,
    WORD_GAP = 3'd5,
    DONE     = 3'd6
  } state_t;

  // Returns {len[2:0], pattern[4:0]}; pattern is MSB-first, 1 = dash.
  // len 0 marks a code with no Morse representation.
  function automatic logic [7:0] decode(input logic [5:0] code);
    logic [7:0] d;
    d = 8'd0;
    case (code)
      6'd0:  d = {3'd2, 5'b01000};  // A .-
      6'd1:  d = {3'd4, 5'b10000};  // B -...
      6'd2:  d = {3'd4, 5'b10100};  // C -.-.
      6'd3:  d = {3'd3, 5'b10000};  // D -..
      6'd4:  d = {3'd1, 5'b00000};  // E .
      6'd5:  d = {3'd4, 5'b00100};  // F ..-.
      6'd6:  d = {3'd3, 5'b11000};  // G --.
      6'd7:  d = {3'd4, 5'b00000};  // H ....
      6'd8:  d = {3'd2, 5'b00000};  // I ..
      6'd9:  d = {3'd4, 5'b01110};  // J .---
      6'd10: d = {3'd3, 5'b10100};  // K -.-
      6'd11: d = {3'd4, 5'b01000};  // L .-..
      6'd12: d = {3'd2, 5'b11000};  // M --
      6'd13: d = {3'd2, 5'b10000};  // N -.
      6'd14: d = {3'd3, 5'b11100};  // O ---
      6'd15: d = {3'd4, 5'b01100};  // P .--.
      6'd16: d = {3'd4, 5'b11010};  // Q --.-
      6'd17: d = {3'd3, 5'b01000};  // R .-.
      6'd18: d = {3'd3, 5'b00000};  // S ...
      6'd19: d = {3'd1, 5'b10000};  // T -
      6'd20: d = {3'd3, 5'b00100};  // U ..-
      6'd21: d = {3'd4, 5'b00010};  // V ...-
      6'd22: d = {3'd3, 5'b01100};  // W .--
      6'd23: d = {3'd4, 5'b10010};  // X -..-
      6'd24: d = {3'd4, 5'b10110};  // Y -.--
      6'd25: d = {3'd4, 5'b11000};  // Z --..
`ifdef MORSE_KEYER_DIGITS_EN
      6'd27: d = {3'd5, 5'b11111};  // 0 -----
      6'd28: d = {3'd5, 5'b01111};  // 1 .----
      6'd29: d = {3'd5, 5'b00111};  // 2 ..---
      6'd30: d = {3'd5, 5'b00011};  // 3 ...--
      6'd31: d = {3'd5, 5'b00001};  // 4 ....-
      6'd32: d = {3'd5, 5'b00000};  // 5 .....
      6'd33: d = {3'd5, 5'b10000};  // 6 -....
      6'd34: d = {3'd5, 5'b11000};  // 7 --...
      6'd35: d = {3'd5, 5'b11100};  // 8 ---..
      6'd36: d = {3'd5, 5'b11110};  // 9 ----.
`endif
      default: d = 8'd0;
    endcase
    return d;
  endfunction

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_prev;
  logic                   tick;
  logic [7:0]             dec;
  logic [2:0]             dec_len;
  logic [4:0]             dec_pat;

  state_t     state;
  logic [2:0] unit_cnt;
  logic [2:0] sym_idx;
  logic [2:0] len_q;
  logic [4:0] pat_q;     // shifted left per symbol; bit 4 is the current one
  logic [2:0] mark_last;
  logic       accept;

  assign tick      = sync_q[SYNC_STAGES-1] & ~sync_prev;
  assign dec       = decode(char_bus.char_in);
  assign dec_len   = dec[7:5];
  assign dec_pat   = dec[4:0];
  assign mark_last = pat_q[4] ? DASH_LAST : 3'd0;
  assign accept    = char_bus.char_valid & char_bus.char_ready;

  // Bring unit_clk into the CLOCK_50 domain and keep its previous value for
  // rising-edge detection.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      sync_q    <= '0;
      sync_prev <= 1'b0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], unit_clk};
      sync_prev <= sync_q[SYNC_STAGES-1];
    end
  end

  // Character sequencer with registered key, status and handshake outputs.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state               <= IDLE;
      unit_cnt            <= 3'd0;
      sym_idx             <= 3'd0;
      len_q               <= 3'd0;
      pat_q               <= 5'd0;
      key_out             <= 1'b0;
      busy                <= 1'b0;
      char_done           <= 1'b0;
      bad_char            <= 1'b0;
      char_bus.char_ready <= 1'b1;
    end else begin
      char_done <= 1'b0;
      bad_char  <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            char_bus.char_ready <= 1'b0;
            busy                <= 1'b1;
            unit_cnt            <= 3'd0;
            sym_idx             <= 3'd0;
            if (char_bus.char_in == CODE_SPACE) begin
              state <= WORD_GAP;
            end else if (dec_len == 3'd0) begin
              state     <= DONE;
              char_done <= 1'b1;
              bad_char  <= 1'b1;
            end else begin
              len_q <= dec_len;
              pat_q <= dec_pat;
              state <= ALIGN;
            end
          end
        end
        ALIGN: begin
          if (tick) begin
            key_out  <= 1'b1;
            unit_cnt <= 3'd0;
            state    <= MARK;
          end
        end
        MARK: begin
          if (tick) begin
            if (unit_cnt == mark_last) begin
              key_out  <= 1'b0;
              unit_cnt <= 3'd0;
              if (sym_idx + 3'd1 == len_q) begin
                state <= CHAR_GAP;
              end else begin
                sym_idx <= sym_idx + 3'd1;
                pat_q   <= pat_q << 1;
                state   <= SYM_GAP;
              end
            end else begin
              unit_cnt <= unit_cnt + 3'd1;
            end
          end
        end
        SYM_GAP: begin
          if (tick) begin
            key_out  <= 1'b1;
            unit_cnt <= 3'd0;
            state    <= MARK;
          end
        end
        CHAR_GAP: begin
          if (tick) begin
            if (unit_cnt == CGAP_LAST) begin
              state     <= DONE;
              char_done <= 1'b1;
            end else begin
              unit_cnt <= unit_cnt + 3'd1;
            end
          end
        end
        WORD_GAP: begin
          if (tick) begin
            if (unit_cnt == WGAP_LAST) begin
              state     <= DONE;
              char_done <= 1'b1;
            end else begin
              unit_cnt <= unit_cnt + 3'd1;
            end
          end
        end
        DONE: begin
          busy                <= 1'b0;
          char_bus.char_ready <= 1'b1;
          state               <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_morse_keyer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_morse_keyer
//  Description : Self-checking bench for morse_keyer. Expected key waveforms
//                are built from Morse strings and unit timing; unit_clk has a
//                20-cycle period derived from the bench cycle counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_morse_keyer;

  localparam int UNIT = 20;
  localparam int DASH = 3;
  localparam int CGAP = 3;
  localparam int WGAP = 4;

  logic CLOCK_50 = 1'b0;
  logic reset_n  = 1'b0;
  logic unit_clk = 1'b0;
  logic key_out;
  logic busy;
  logic char_done;
  logic bad_char;

  morse_keyer_if bus ();

  morse_keyer #(
    .SYNC_STAGES      (2),
    .DASH_UNITS       (DASH),
    .CHAR_GAP_UNITS   (CGAP),
    .WORD_EXTRA_UNITS (WGAP)
  ) dut (
    .CLOCK_50  (CLOCK_50),
    .reset_n   (reset_n),
    .unit_clk  (unit_clk),
    .char_bus  (bus),
    .key_out   (key_out),
    .busy      (busy),
    .char_done (char_done),
    .bad_char  (bad_char)
  );

  int cyc         = 0;
  int ph          = 0;
  int tests       = 0;
  int fails       = 0;
  int last_accept = 0;
  int last_end    = 0;

  string letters [26] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....",
                          "..", ".---", "-.-", ".-..", "--", "-.", "---", ".--.",
                          "--.-", ".-.", "...", "-", "..-", "...-", ".--", "-..-",
                          "-.--", "--.."};

  typedef struct {
    logic [5:0] code;
    string      morse;
    bit         space;
    bit         bad;
    string      name;
  } vec_t;

  vec_t vecs[$];

  always #10 CLOCK_50 = ~CLOCK_50;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance one clock; afterwards cyc is the number of the edge just taken.
  task automatic step();
    @(posedge CLOCK_50);
    #1;
    cyc++;
    unit_clk = (((cyc + ph) % UNIT) >= (UNIT / 2));
  endtask

  // unit_clk rises just after edge c with (c+ph)%20==10; the keyer acts on
  // that rise three edges later (two sync stages plus the edge detector).
  function automatic bit is_tick(input int e);
    return ((e + 17 + ph) % UNIT) == 10;
  endfunction

  task automatic check(input string name, input bit ok, input string detail);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: %s", name, detail);
    end
  endtask

  task automatic code_info(input int code, output string m, output bit sp, output bit bad);
    m   = "";
    sp  = 1'b0;
    bad = 1'b0;
    if (code < 26) begin
      m = letters[code];
    end else if (code == 26) begin
      sp = 1'b1;
    end else if (code <= 36) begin
`ifdef MORSE_KEYER_DIGITS_EN
      int d;
      d = code - 27;
      for (int k = 0; k < 5; k++) begin
        if (d <= 5) m = {m, (k < d) ? "." : "-"};
        else        m = {m, (k < d - 5) ? "-" : "."};
      end
`else
      bad = 1'b1;
`endif
    end else begin
      bad = 1'b1;
    end
  endtask

  task automatic wait_accept(output int a, output bit ok);
    int g;
    g  = 0;
    ok = 1'b0;
    a  = cyc;
    while (bus.char_ready !== 1'b1 && g < 2000) begin
      step();
      g++;
    end
    if (bus.char_ready === 1'b1) begin
      step();
      a  = cyc;
      ok = 1'b1;
    end
  endtask

  // Send one character and compare every output on every cycle from the
  // accepting edge until the keyer is ready again.
  task automatic run_char(input logic [5:0] code, input string morse, input bit sp,
                          input bit bad, input bit keep_valid, input logic [5:0] next_code,
                          input string name);
    int    a, t0, pos, u, fin;
    bit    ok, good;
    int    ks[$];
    int    ke[$];
    string detail;
    bit    ek, eb, er, ed, ebad;

    bus.char_in    = code;
    bus.char_valid = 1'b1;
    wait_accept(a, ok);
    if (!ok) begin
      check(name, 1'b0, "char_ready never rose, character not accepted");
      bus.char_valid = 1'b0;
      return;
    end
    if (keep_valid) begin
      bus.char_in = next_code;
    end else begin
      bus.char_valid = 1'b0;
      bus.char_in    = 6'($urandom);
    end

    t0 = a + 1;
    while (!is_tick(t0)) t0++;
    if (bad) begin
      fin = a;
    end else if (sp) begin
      fin = t0 + WGAP * UNIT;
    end else begin
      pos = t0;
      for (int i = 0; i < morse.len(); i++) begin
        u = (morse[i] == "-") ? DASH : 1;
        ks.push_back(pos);
        ke.push_back(pos + u * UNIT);
        pos += u * UNIT;
        if (i < morse.len() - 1) pos += UNIT;
      end
      fin = pos + CGAP * UNIT;
    end

    good   = 1'b1;
    detail = "";
    for (int e = a; e <= fin + 1; e++) begin
      if (e > a) step();
      ek = 1'b0;
      foreach (ks[j]) if (e >= ks[j] && e < ke[j]) ek = 1'b1;
      eb   = (e <= fin);
      er   = (e > fin);
      ed   = (e == fin);
      ebad = bad && (e == fin);
      if (good && (key_out !== ek || busy !== eb || bus.char_ready !== er ||
                   char_done !== ed || bad_char !== ebad)) begin
        good   = 1'b0;
        detail = $sformatf("cycle +%0d got key=%b busy=%b ready=%b done=%b bad=%b, expected key=%b busy=%b ready=%b done=%b bad=%b",
                           e - a, key_out, busy, bus.char_ready, char_done, bad_char,
                           ek, eb, er, ed, ebad);
      end
    end
    check(name, good, detail);
    last_accept = a;
    last_end    = fin;
  endtask

  initial begin
    int    a, t0, end_t, code, gap;
    bit    ok, q, sp, bad;
    string m;

    ph             = $urandom_range(0, UNIT - 1);
    unit_clk       = ((ph % UNIT) >= (UNIT / 2));
    bus.char_in    = 6'd0;
    bus.char_valid = 1'b0;
    reset_n        = 1'b0;

    repeat (5) step();
    check("reset_state",
          key_out === 1'b0 && busy === 1'b0 && bus.char_ready === 1'b1 &&
          char_done === 1'b0 && bad_char === 1'b0,
          $sformatf("got key=%b busy=%b ready=%b done=%b bad=%b, expected 0 0 1 0 0",
                    key_out, busy, bus.char_ready, char_done, bad_char));
    reset_n = 1'b1;
    repeat (30) step();

    vecs.push_back('{6'd4,  ".",    1'b0, 1'b0, "E"});
    vecs.push_back('{6'd0,  ".-",   1'b0, 1'b0, "A"});
    vecs.push_back('{6'd19, "-",    1'b0, 1'b0, "T"});
    vecs.push_back('{6'd26, "",     1'b1, 1'b0, "space"});
    vecs.push_back('{6'd63, "",     1'b0, 1'b1, "code63"});
    vecs.push_back('{6'd16, "--.-", 1'b0, 1'b0, "Q"});
    vecs.push_back('{6'd25, "--..", 1'b0, 1'b0, "Z"});
`ifdef MORSE_KEYER_DIGITS_EN
    vecs.push_back('{6'd27, "-----", 1'b0, 1'b0, "digit0"});
    vecs.push_back('{6'd36, "----.", 1'b0, 1'b0, "digit9"});
`else
    vecs.push_back('{6'd27, "",     1'b0, 1'b1, "digit0_off"});
    vecs.push_back('{6'd36, "",     1'b0, 1'b1, "digit9_off"});
`endif
    vecs.push_back('{6'd37, "",     1'b0, 1'b1, "code37"});

    foreach (vecs[i]) begin
      run_char(vecs[i].code, vecs[i].morse, vecs[i].space, vecs[i].bad,
               1'b0, 6'd0, vecs[i].name);
      repeat (3 + 7 * i) step();
    end

    // T then space with char_valid held across the boundary.
    run_char(6'd19, "-", 1'b0, 1'b0, 1'b1, 6'd26, "T_b2b");
    end_t = last_end;
    run_char(6'd26, "", 1'b1, 1'b0, 1'b0, 6'd0, "space_b2b");
    check("b2b_accept", last_accept == end_t + 2,
          $sformatf("space accepted %0d cycles after T done, expected 2",
                    last_accept - end_t));
    repeat (11) step();

    // Reset in the middle of the second dash of 'O'.
    bus.char_in    = 6'd14;
    bus.char_valid = 1'b1;
    wait_accept(a, ok);
    bus.char_valid = 1'b0;
    check("O_accept", ok, "char_ready never rose");
    t0 = a + 1;
    while (!is_tick(t0)) t0++;
    while (cyc < t0 + 4 * UNIT + 20) step();
    check("O_dash2_key", key_out === 1'b1,
          $sformatf("key=%b, expected 1", key_out));
    #3;
    reset_n = 1'b0;
    #1;
    check("abort_async",
          key_out === 1'b0 && busy === 1'b0 && bus.char_ready === 1'b1 && char_done === 1'b0,
          $sformatf("got key=%b busy=%b ready=%b done=%b, expected 0 0 1 0",
                    key_out, busy, bus.char_ready, char_done));
    repeat (4) step();
    reset_n = 1'b1;
    q = 1'b1;
    repeat (30) begin
      step();
      if (char_done !== 1'b0 || key_out !== 1'b0 || busy !== 1'b0 || bus.char_ready !== 1'b1)
        q = 1'b0;
    end
    check("abort_quiet", q, $sformatf("after reset got key=%b busy=%b ready=%b done=%b, expected 0 0 1 0",
                                      key_out, busy, bus.char_ready, char_done));
    run_char(6'd4, ".", 1'b0, 1'b0, 1'b0, 6'd0, "E_after_reset");

    // Random characters with random idle gaps.
    for (int i = 0; i < 30; i++) begin
      code = $urandom_range(0, 63);
      code_info(code, m, sp, bad);
      gap = $urandom_range(0, 25);
      repeat (gap) step();
      run_char(6'(code), m, sp, bad, 1'b0, 6'd0, $sformatf("rand%0d_code%0d", i, code));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
